alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the team's 8-bit single-cycle ALU. It accepts one operation at a time over a valid/ready input channel and returns a registered 2×WIDTH result with status flags over a valid/ready output channel. MUL is a sequential shift-add operation; all other opcodes take one cycle. It sits between the test-stimulus sequencer and the scoreboard-facing result bus.

## Interface
- WIDTH, 8: operand width in bits (≥2). The result is 2*WIDTH bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  block can accept; high only in IDLE
- op_code  input  4  operation select
- a, b  input  WIDTH  operands, unsigned
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  2*WIDTH  registered result
- carry  output  1  ADD carry-out / SUB borrow
- zero  output  1  result == 0
- err  output  1  illegal opcode

## Operation
- Reset values: in_ready=0 while rst is high, then 1 in IDLE. out_valid, result, carry, zero and err are all 0. State is IDLE and the counter is 0.
- States:
  - IDLE: in_ready=1. On an in_valid edge, latch a, b and op_code.
    - If op_code is MUL, go to MUL and clear the accumulator and counter.
    - For any other opcode, compute and register result and flags, then go to DONE.
  - MUL: in_ready=0. Each cycle, if b_reg[cnt]=1, add (a_reg << cnt) to the accumulator. Increment cnt. When cnt reaches WIDTH-1, the final add is written to result and the state moves to DONE.
  - DONE: out_valid=1 and outputs are held stable. On an out_ready edge, clear out_valid and go to IDLE. in_valid is ignored in this state.
- Opcodes (results are zero-extended to 2*WIDTH unless noted):
  - 0 ADD: a+b, WIDTH+1 bits. carry = bit WIDTH.
  - 1 SUB: (a-b) mod 2^(2*WIDTH). carry = (a<b).
  - 2 MUL: a*b, exact.
  - 3 OR: a|b.
  - 4 XOR: a^b.
  - 5 AND: a&b.
  - 6 NAND: ~(a&b), WIDTH bits. Upper bits are 0.
  - 7 NOR: ~(a|b), WIDTH bits. Upper bits are 0.
  - 8 SHL: ({0,a} << b), truncated to 2*WIDTH. Result is 0 if b ≥ 2*WIDTH.
  - 9 SHR: a >> b. Result is 0 if b ≥ WIDTH.
  - 10 SLTU: 1 if a<b, else 0.
  - 11–15 illegal: result=0, err=1.
- carry is 0 for every opcode except ADD and SUB. zero is computed from the final result for every opcode, including illegal ones (so zero=1 with err=1).
- Operands are sampled only at the accept edge. Input changes after acceptance have no effect.
- If rst is asserted in any state, including mid-MUL or DONE with out_ready low, all outputs return to their reset values immediately and the in-flight operation is discarded.

## Timing
- Accept occurs on the edge where in_valid && in_ready.
- Non-MUL latency: out_valid rises on the accept edge, so the result is visible in the next cycle (1 cycle).
- MUL latency: out_valid rises WIDTH edges after the accept edge (8 cycles at WIDTH=8).
- Output handshake completes on the edge where out_valid && out_ready. in_ready rises on that same edge.
- Peak throughput is one non-MUL operation every 2 cycles. A new accept cannot occur in the same cycle as output completion.
- Backpressure: out_valid stays high and result/flags stay unchanged for any number of cycles while out_ready=0.
- out_ready high while out_valid=0 has no effect.

## Test plan
1. Reset mid-MUL: with WIDTH=8, accept MUL a=15, b=15, then assert rst on cycle 3. out_valid stays 0 and result=0; after release in_ready=1 and no stale result appears.
2. ADD a=8'hFF, b=8'h01 with out_ready=1 -> one cycle later result=16'h0100, carry=1, zero=0, err=0. SUB a=0, b=1 -> result=16'hFFFF, carry=1.
3. MUL a=8'hFF, b=8'hFF -> out_valid exactly 8 cycles after accept with result=16'hFE01. in_ready stays 0 throughout. MUL a=0, b=200 -> result=0, zero=1.
4. NAND a=8'hF0, b=8'hFF -> result=16'h000F. SHL a=8'h81, b=9 -> 16'h0200. SHL b=16 -> 0, zero=1. SHR a=8'h80, b=7 -> 1. SLTU a=3, b=5 -> 1.
5. Illegal op_code=4'hC with a=5, b=5 -> result=0, err=1, zero=1, carry=0. The next legal op clears err.
6. Backpressure: hold out_ready=0 for 10 cycles after XOR a=8'hAA, b=8'h55. result=16'h00FF stays stable, in_ready=0, and a new in_valid with changed operands is ignored. Raising out_ready completes the handshake and in_ready=1 on the following cycle.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with a registered 2*WIDTH result and a sequential shift-add multiply
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op_code,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 zero,
  output logic                 err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [2*WIDTH-1:0]   acc;

  logic [2*WIDTH-1:0]   a_ext;
  logic [2*WIDTH-1:0]   b_ext;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   alu_res;
  logic                 alu_carry;
  logic                 alu_err;

  logic [2*WIDTH-1:0]   a_reg_ext;
  logic [2*WIDTH-1:0]   mul_add;
  logic [2*WIDTH-1:0]   acc_next;

  assign in_ready = (state == ST_IDLE) && !rst;

  assign a_ext = {{WIDTH{1'b0}}, a};
  assign b_ext = {{WIDTH{1'b0}}, b};
  assign sum   = {1'b0, a} + {1'b0, b};

  // Single-cycle opcodes are evaluated straight from the input bus at the accept edge.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (op_code)
      OP_ADD: begin
        alu_res   = {{(WIDTH-1){1'b0}}, sum};
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res   = a_ext - b_ext;
        alu_carry = (a < b);
      end
      OP_MUL:  alu_res = '0;
      OP_OR:   alu_res = a_ext | b_ext;
      OP_XOR:  alu_res = a_ext ^ b_ext;
      OP_AND:  alu_res = a_ext & b_ext;
      OP_NAND: alu_res = {{WIDTH{1'b0}}, ~(a & b)};
      OP_NOR:  alu_res = {{WIDTH{1'b0}}, ~(a | b)};
      // Shift amounts past the vector width shift everything out, giving 0.
      OP_SHL:  alu_res = a_ext << b;
      OP_SHR:  alu_res = a_ext >> b;
      OP_SLTU: alu_res = {{(2*WIDTH-1){1'b0}}, (a < b)};
      default: alu_err = 1'b1;
    endcase
  end

  assign a_reg_ext = {{WIDTH{1'b0}}, a_reg};
  assign mul_add   = b_reg[cnt] ? (a_reg_ext << cnt) : '0;
  assign acc_next  = acc + mul_add;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            if (op_code == OP_MUL) begin
              acc   <= '0;
              cnt   <= '0;
              state <= ST_MUL;
            end else begin
              result    <= alu_res;
              carry     <= alu_carry;
              zero      <= (alu_res == '0);
              err       <= alu_err;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          // The last partial product is folded straight into the result register.
          if (cnt == CNT_LAST) begin
            result    <= acc_next;
            carry     <= 1'b0;
            zero      <= (acc_next == '0);
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=8
module tb_alu_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     op_code;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           carry;
  logic           zero;
  logic           err;

  int passes = 0;
  int total  = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_code   (op_code),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] av,
                        input logic [7:0] bv, input logic [15:0] er,
                        input logic ec, input logic ez, input logic ee);
    int n;
    in_valid = 1'b1;
    op_code  = op;
    a        = av;
    b        = bv;
    tick();
    in_valid = 1'b0;
    a        = ~av;
    b        = ~bv;
    n = 0;
    while (!out_valid && n < 20) begin
      check({tag, "_busy_in_ready"}, in_ready, 0);
      tick();
      n++;
    end
    check({tag, "_latency"}, n, (op == 4'd2) ? 8 : 0);
    check({tag, "_result"}, result, er);
    check({tag, "_carry"}, carry, ec);
    check({tag, "_zero"}, zero, ez);
    check({tag, "_err"}, err, ee);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_done_valid"}, out_valid, 0);
    check({tag, "_done_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int  n;
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_code   = 4'd0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {carry, zero, err}, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);

    run_op("add_ff_01", 4'd0, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 1'b0);

    // MUL interrupted by reset on its third cycle
    in_valid = 1'b1;
    op_code  = 4'd2;
    a        = 8'd15;
    b        = 8'd15;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midmul_rst_valid", out_valid, 0);
    check("midmul_rst_result", result, 0);
    check("midmul_rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("midmul_release_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midmul_no_stale", seen, 0);

    run_op("sub_0_1", 4'd1, 8'h00, 8'h01, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("mul_ff_ff", 4'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b0);
    run_op("mul_0_200", 4'd2, 8'h00, 8'd200, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("mul_3_5", 4'd2, 8'd3, 8'd5, 16'd15, 1'b0, 1'b0, 1'b0);
    run_op("nand_f0_ff", 4'd6, 8'hF0, 8'hFF, 16'h000F, 1'b0, 1'b0, 1'b0);
    run_op("nor_0f_30", 4'd7, 8'h0F, 8'h30, 16'h00C0, 1'b0, 1'b0, 1'b0);
    run_op("shl_81_9", 4'd8, 8'h81, 8'd9, 16'h0200, 1'b0, 1'b0, 1'b0);
    run_op("shl_81_16", 4'd8, 8'h81, 8'd16, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("shr_80_7", 4'd9, 8'h80, 8'd7, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("shr_80_8", 4'd9, 8'h80, 8'd8, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("sltu_3_5", 4'd10, 8'd3, 8'd5, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("sltu_5_3", 4'd10, 8'd5, 8'd3, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("and_3c_0f", 4'd5, 8'h3C, 8'h0F, 16'h000C, 1'b0, 1'b0, 1'b0);
    run_op("illegal_c", 4'hC, 8'd5, 8'd5, 16'h0000, 1'b0, 1'b1, 1'b1);
    run_op("or_after_illegal", 4'd3, 8'd5, 8'd5, 16'h0005, 1'b0, 1'b0, 1'b0);

    // Backpressure on an XOR result while a second request is presented
    in_valid = 1'b1;
    op_code  = 4'd4;
    a        = 8'hAA;
    b        = 8'h55;
    tick();
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        op_code  = 4'd0;
        a        = 8'h01;
        b        = 8'h01;
      end
      if (!(out_valid === 1'b1 && result === 16'h00FF && in_ready === 1'b0)) n++;
      tick();
    end
    check("bp_hold_violations", n, 0);
    check("bp_result", result, 16'h00FF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_done_valid", out_valid, 0);
    check("bp_done_in_ready", in_ready, 1);
    check("bp_result_kept", result, 16'h00FF);
    in_valid = 1'b0;
    tick();
    check("bp_no_accept", out_valid, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
